// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - iterative radix-2 Booth signed multiplier with valid/ready handshakes
// Runs one Booth add/subtract-and-shift per clock over a shared accumulator and Q register.
module booth_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   multiplicand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W:0]       acc;
  logic [W-1:0]     q;
  logic [W-1:0]     m;
  logic             q_1;
  logic [CNT_W-1:0] count;

  logic [W:0]       m_ext;
  logic [W:0]       sum;
  logic [W:0]       acc_nxt;
  logic [W-1:0]     q_nxt;

  // One extra accumulator bit keeps -2^(W-1) multiplicands from overflowing the add/subtract.
  always_comb begin
    m_ext = {m[W-1], m};
    sum   = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    acc_nxt = {sum[W], sum[W:1]};
    q_nxt   = {sum[0], q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      q_1       <= 1'b0;
      count     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m        <= multiplicand;
            q        <= multiplier;
            acc      <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          q     <= q_nxt;
          q_1   <= q[0];
          count <= count + CNT_W'(1);
          if (count == CNT_W'(W - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= {acc_nxt[W-1:0], q_nxt};
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - self-checking bench for booth_seq_ctrl
// Golden products come from plain signed integer multiplication.
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplier;
  logic [7:0]  multiplicand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  booth_seq_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  m;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    return 16'(ai * bi);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    multiplier   = a;
    multiplicand = b;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges since the accepting edge until out_valid; also confirms busy/in_ready in RUN.
  task automatic wait_done(input int start, output int lat);
    bit flags_ok = 1'b1;
    lat = start;
    while (!out_valid && lat < 50) begin
      if (!busy || in_ready) flags_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("run_flags", 32'(flags_ok), 1);
    chk("latency", lat, 8);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 0);
    chk("consume_in_ready", 32'(in_ready), 1);
    chk("consume_busy", 32'(busy), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int lat;
    logic [15:0] held;
    logic [7:0] ra, rb;
    bit hold_ok;
    int times[$];
    logic [15:0] expq[$];
    int n_acc, n_got;
    bit acc_now;

    vecs[0] = '{8'd3,    8'hFB, 16'hFFF1};
    vecs[1] = '{8'h80,   8'h80, 16'h4000};
    vecs[2] = '{8'h7F,   8'h80, 16'hC080};
    vecs[3] = '{8'h00,   8'hB3, 16'h0000};
    vecs[4] = '{8'hFF,   8'hFF, 16'h0001};
    vecs[5] = '{8'hF9,   8'h09, 16'hFFC1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    multiplier = '0; multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_product", 32'(product), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].q, vecs[i].m);
      wait_done(0, lat);
      chk($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp));
      consume();
    end

    // Backpressure: product and flags must hold for 20 stalled cycles.
    start_op(8'h5A, 8'hC3);
    wait_done(0, lat);
    held = product;
    chk("bp_product", 32'(held), 32'(model(8'h5A, 8'hC3)));
    hold_ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (product !== held || !out_valid || in_ready || !busy) hold_ok = 1'b0;
    end
    chk("bp_hold", 32'(hold_ok), 1);
    consume();

    // Input isolation: operand churn and in_valid pulses during RUN are ignored.
    start_op(8'h15, 8'hE7);
    for (int i = 0; i < 4; i++) begin
      multiplier   = 8'($urandom);
      multiplicand = 8'($urandom);
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(4, lat);
    chk("iso_product", 32'(product), 32'(model(8'h15, 8'hE7)));
    consume();

    // Reset on the 4th iteration edge aborts cleanly.
    start_op(8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_product", 32'(product), 0);
    start_op(8'hF9, 8'h09);
    wait_done(0, lat);
    chk("midrst_new_product", 32'(product), 32'h0000FFC1);
    consume();

    // Randomized operands with random consumer stalls.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb);
      wait_done(0, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk($sformatf("rand%0d_product", i), 32'(product), 32'(model(ra, rb)));
      consume();
    end

    // Back-to-back: in_valid held high, consumer always ready.
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    multiplier   = 8'($urandom);
    multiplicand = 8'($urandom);
    n_acc = 0;
    n_got = 0;
    for (int c = 0; c < 80 && n_got < 4; c++) begin
      @(negedge clk);
      acc_now = in_ready && in_valid;
      if (out_valid && expq.size() > 0) begin
        chk($sformatf("b2b%0d_product", n_got), 32'(product), 32'(expq.pop_front()));
        n_got++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        times.push_back(cyc);
        expq.push_back(model(multiplier, multiplicand));
        n_acc++;
        if (n_acc == 4) in_valid = 1'b0;
        else begin
          multiplier   = 8'($urandom);
          multiplicand = 8'($urandom);
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", n_got, 4);
    for (int i = 1; i < times.size(); i++)
      chk($sformatf("b2b_spacing%0d", i), times[i] - times[i-1], 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
